microcode_store_ram: RTL and testbench

//  Writable, registered control store for the ARC microarchitecture: DEPTH x 41-bit microword RAM feeding a MIR register.

---
 rtl/microcode_store_ram.sv | 168 ++++++++++++++++
 tb/tb_microcode_store_ram.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/microcode_store_ram.sv
// Writable control store for the ARC microarchitecture. A DEPTH x 41-bit RAM feeds the MIR register.
// The RAM is scrubbed to FETCH_WORD after every reset and is loaded at run time through a valid/ready write port.
module microcode_store_ram #(
    parameter int DATAWIDTH_JUMPADDRESS      = 11,
    parameter int DEPTH                      = 2048,
    parameter int DATAWIDTH_MIR_DIRECTION    = 6,
    parameter int DATAWIDTH_ALU_SELECTION    = 4,
    parameter int DATAWIDTH_CONDITION        = 3,
    parameter int DATAWIDTH_MICROINSTRUCTION = 41,
    parameter logic [DATAWIDTH_MICROINSTRUCTION-1:0] FETCH_WORD =
        41'b10000001000000100101010010100000000000000
) (
    input  logic                                  MICROCODE_STORE_RAM_CLOCK_50,
    input  logic                                  MICROCODE_STORE_RAM_ResetInHigh_In,
    input  logic [DATAWIDTH_JUMPADDRESS-1:0]      MICROCODE_STORE_RAM_CSAddress_InBus,
    input  logic                                  MICROCODE_STORE_RAM_Stall_In,
    input  logic                                  MICROCODE_STORE_RAM_WrValid_In,
    output logic                                  MICROCODE_STORE_RAM_WrReady_Out,
    input  logic [DATAWIDTH_JUMPADDRESS-1:0]      MICROCODE_STORE_RAM_WrAddress_InBus,
    input  logic [DATAWIDTH_MICROINSTRUCTION-1:0] MICROCODE_STORE_RAM_WrData_InBus,
    output logic                                  MICROCODE_STORE_RAM_InitDone_Out,
    output logic                                  MICROCODE_STORE_RAM_SelectA_Out,
    output logic                                  MICROCODE_STORE_RAM_SelectB_Out,
    output logic                                  MICROCODE_STORE_RAM_SelectC_Out,
    output logic [DATAWIDTH_MIR_DIRECTION-1:0]    MICROCODE_STORE_RAM_DirA_OutBus,
    output logic [DATAWIDTH_MIR_DIRECTION-1:0]    MICROCODE_STORE_RAM_DirB_OutBus,
    output logic [DATAWIDTH_MIR_DIRECTION-1:0]    MICROCODE_STORE_RAM_DirC_OutBus,
    output logic                                  MICROCODE_STORE_RAM_RD_Out,
    output logic                                  MICROCODE_STORE_RAM_WRMain_Out,
    output logic [DATAWIDTH_ALU_SELECTION-1:0]    MICROCODE_STORE_RAM_ALUOperation_OutBus,
    output logic [DATAWIDTH_CONDITION-1:0]        MICROCODE_STORE_RAM_Condition_OutBus,
    output logic [DATAWIDTH_JUMPADDRESS-1:0]      MICROCODE_STORE_RAM_JumpAddress_OutBus
);

    localparam int JW  = DATAWIDTH_JUMPADDRESS;
    localparam int DW  = DATAWIDTH_MIR_DIRECTION;
    localparam int MW  = DATAWIDTH_MICROINSTRUCTION;
    localparam int RAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SCW = $clog2(DEPTH) + 1;

    localparam logic [JW:0]    DEPTH_EXT  = DEPTH[JW:0];
    localparam logic [SCW-1:0] SCRUB_LAST = SCW'(DEPTH - 1);

    // Field positions, packed from the jump address upwards.
    localparam int POS_COND = JW;
    localparam int POS_ALU  = POS_COND + DATAWIDTH_CONDITION;
    localparam int POS_WR   = POS_ALU + DATAWIDTH_ALU_SELECTION;
    localparam int POS_RD   = POS_WR + 1;
    localparam int POS_DIRC = POS_RD + 1;
    localparam int POS_SELC = POS_DIRC + DW;
    localparam int POS_DIRB = POS_SELC + 1;
    localparam int POS_SELB = POS_DIRB + DW;
    localparam int POS_DIRA = POS_SELB + 1;
    localparam int POS_SELA = POS_DIRA + DW;

    typedef enum logic {INIT, RUN} stateType;

    logic clk;
    logic rst;
    assign clk = MICROCODE_STORE_RAM_CLOCK_50;
    assign rst = MICROCODE_STORE_RAM_ResetInHigh_In;

    stateType         state, nextState;
    logic [SCW-1:0]   scrubCount;
    logic [MW-1:0]    mir;
    logic [MW-1:0]    ram [DEPTH];

    logic             wrReady, initDone;
    logic             ramWe;
    logic [RAW-1:0]   ramWrAddr;
    logic [MW-1:0]    ramWrData;
    logic             csInRange, wrInRange;
    logic [RAW-1:0]   csIndex;

    assign csInRange = {1'b0, MICROCODE_STORE_RAM_CSAddress_InBus} < DEPTH_EXT;
    assign wrInRange = {1'b0, MICROCODE_STORE_RAM_WrAddress_InBus} < DEPTH_EXT;
    assign csIndex   = MICROCODE_STORE_RAM_CSAddress_InBus[RAW-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= nextState;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        nextState = state;
        wrReady   = 1'b0;
        initDone  = 1'b0;
        case (state)
            INIT: begin
                if (scrubCount == SCRUB_LAST) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                wrReady  = 1'b1;
                initDone = 1'b1;
            end
            default: nextState = INIT;
        endcase
    end

    // Counter stops at DEPTH once RUN is reached; it only restarts on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scrubCount <= '0;
        end else if (state == INIT) begin
            scrubCount <= scrubCount + 1'b1;
        end
    end

    always_comb begin
        ramWe     = 1'b0;
        ramWrAddr = '0;
        ramWrData = FETCH_WORD;
        if (state == INIT) begin
            ramWe     = 1'b1;
            ramWrAddr = scrubCount[RAW-1:0];
        end else if (MICROCODE_STORE_RAM_WrValid_In && wrReady && wrInRange) begin
            ramWe     = 1'b1;
            ramWrAddr = MICROCODE_STORE_RAM_WrAddress_InBus[RAW-1:0];
            ramWrData = MICROCODE_STORE_RAM_WrData_InBus;
        end
    end

    // NOTE: the RAM array has no reset; the INIT scrub gives it a known content instead.
    always_ff @(posedge clk) begin
        if (ramWe) begin
            ram[ramWrAddr] <= ramWrData;
        end
    end

    // A write to the address being read forwards the new word into MIR (write-first).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mir <= FETCH_WORD;
        end else if (state == INIT) begin
            mir <= FETCH_WORD;
        end else if (!MICROCODE_STORE_RAM_Stall_In) begin
            if (!csInRange) begin
                mir <= FETCH_WORD;
            end else if (ramWe && (ramWrAddr == csIndex)) begin
                mir <= ramWrData;
            end else begin
                mir <= ram[csIndex];
            end
        end
    end

    assign MICROCODE_STORE_RAM_WrReady_Out          = wrReady;
    assign MICROCODE_STORE_RAM_InitDone_Out         = initDone;
    assign MICROCODE_STORE_RAM_SelectA_Out          = mir[POS_SELA];
    assign MICROCODE_STORE_RAM_DirA_OutBus          = mir[POS_DIRA +: DW];
    assign MICROCODE_STORE_RAM_SelectB_Out          = mir[POS_SELB];
    assign MICROCODE_STORE_RAM_DirB_OutBus          = mir[POS_DIRB +: DW];
    assign MICROCODE_STORE_RAM_SelectC_Out          = mir[POS_SELC];
    assign MICROCODE_STORE_RAM_DirC_OutBus          = mir[POS_DIRC +: DW];
    assign MICROCODE_STORE_RAM_RD_Out               = mir[POS_RD];
    assign MICROCODE_STORE_RAM_WRMain_Out           = mir[POS_WR];
    assign MICROCODE_STORE_RAM_ALUOperation_OutBus  = mir[POS_ALU +: DATAWIDTH_ALU_SELECTION];
    assign MICROCODE_STORE_RAM_Condition_OutBus     = mir[POS_COND +: DATAWIDTH_CONDITION];
    assign MICROCODE_STORE_RAM_JumpAddress_OutBus   = mir[JW-1:0];

endmodule

// File: tb/tb_microcode_store_ram.sv
// Bench for microcode_store_ram: a full-size store plus a DEPTH=1024 build that exercises the out-of-range paths.
// Expected MIR words go into a queue as stimulus is driven and are popped after the clock edge.
module tb_microcode_store_ram;

    localparam logic [40:0] FETCH = 41'b10000001000000100101010010100000000000000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [10:0] cs, wrAddr, cs2, wrAddr2;
    logic        stall, wrValid, stall2, wrValid2;
    logic [40:0] wrData, wrData2;

    logic        wrReady, initDone, selA, selB, selC, rd, wrMain;
    logic [5:0]  dirA, dirB, dirC;
    logic [3:0]  alu;
    logic [2:0]  cond;
    logic [10:0] jump;

    logic        wrReady2, initDone2, selA2, selB2, selC2, rd2, wrMain2;
    logic [5:0]  dirA2, dirB2, dirC2;
    logic [3:0]  alu2;
    logic [2:0]  cond2;
    logic [10:0] jump2;

    wire [40:0] mir  = {selA, dirA, selB, dirB, selC, dirC, rd, wrMain, alu, cond, jump};
    wire [40:0] mir2 = {selA2, dirA2, selB2, dirB2, selC2, dirC2, rd2, wrMain2, alu2, cond2, jump2};

    microcode_store_ram dut (
        .MICROCODE_STORE_RAM_CLOCK_50(clk),
        .MICROCODE_STORE_RAM_ResetInHigh_In(rst),
        .MICROCODE_STORE_RAM_CSAddress_InBus(cs),
        .MICROCODE_STORE_RAM_Stall_In(stall),
        .MICROCODE_STORE_RAM_WrValid_In(wrValid),
        .MICROCODE_STORE_RAM_WrReady_Out(wrReady),
        .MICROCODE_STORE_RAM_WrAddress_InBus(wrAddr),
        .MICROCODE_STORE_RAM_WrData_InBus(wrData),
        .MICROCODE_STORE_RAM_InitDone_Out(initDone),
        .MICROCODE_STORE_RAM_SelectA_Out(selA),
        .MICROCODE_STORE_RAM_SelectB_Out(selB),
        .MICROCODE_STORE_RAM_SelectC_Out(selC),
        .MICROCODE_STORE_RAM_DirA_OutBus(dirA),
        .MICROCODE_STORE_RAM_DirB_OutBus(dirB),
        .MICROCODE_STORE_RAM_DirC_OutBus(dirC),
        .MICROCODE_STORE_RAM_RD_Out(rd),
        .MICROCODE_STORE_RAM_WRMain_Out(wrMain),
        .MICROCODE_STORE_RAM_ALUOperation_OutBus(alu),
        .MICROCODE_STORE_RAM_Condition_OutBus(cond),
        .MICROCODE_STORE_RAM_JumpAddress_OutBus(jump)
    );

    microcode_store_ram #(.DEPTH(1024)) dutSmall (
        .MICROCODE_STORE_RAM_CLOCK_50(clk),
        .MICROCODE_STORE_RAM_ResetInHigh_In(rst),
        .MICROCODE_STORE_RAM_CSAddress_InBus(cs2),
        .MICROCODE_STORE_RAM_Stall_In(stall2),
        .MICROCODE_STORE_RAM_WrValid_In(wrValid2),
        .MICROCODE_STORE_RAM_WrReady_Out(wrReady2),
        .MICROCODE_STORE_RAM_WrAddress_InBus(wrAddr2),
        .MICROCODE_STORE_RAM_WrData_InBus(wrData2),
        .MICROCODE_STORE_RAM_InitDone_Out(initDone2),
        .MICROCODE_STORE_RAM_SelectA_Out(selA2),
        .MICROCODE_STORE_RAM_SelectB_Out(selB2),
        .MICROCODE_STORE_RAM_SelectC_Out(selC2),
        .MICROCODE_STORE_RAM_DirA_OutBus(dirA2),
        .MICROCODE_STORE_RAM_DirB_OutBus(dirB2),
        .MICROCODE_STORE_RAM_DirC_OutBus(dirC2),
        .MICROCODE_STORE_RAM_RD_Out(rd2),
        .MICROCODE_STORE_RAM_WRMain_Out(wrMain2),
        .MICROCODE_STORE_RAM_ALUOperation_OutBus(alu2),
        .MICROCODE_STORE_RAM_Condition_OutBus(cond2),
        .MICROCODE_STORE_RAM_JumpAddress_OutBus(jump2)
    );

    int          checks = 0;
    int          errors = 0;
    logic [40:0] expQ [$];
    logic [40:0] exp2Q [$];
    logic [40:0] model [2048];
    logic [40:0] expWord;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Releases reset and counts edges until InitDone; both stores start their scrub together.
    task automatic scrub_and_time(input string tag);
        bit mirStable = 1'b1;
        int doneAt    = -1;
        int done2At   = -1;
        rst = 1'b0;
        for (int n = 1; n <= 2100 && doneAt < 0; n++) begin
            tick();
            if (mir !== FETCH) mirStable = 1'b0;
            if (done2At < 0 && initDone2 === 1'b1) done2At = n;
            if (initDone === 1'b1) doneAt = n;
        end
        wrValid = 1'b0;
        checks++;
        if (doneAt !== 2048) begin
            errors++;
            $display("FAIL %s_init_done_cycle: got %0d expected 2048", tag, doneAt);
        end
        checks++;
        if (done2At !== 1024) begin
            errors++;
            $display("FAIL %s_small_init_done_cycle: got %0d expected 1024", tag, done2At);
        end
        checks++;
        if (!mirStable) begin
            errors++;
            $display("FAIL %s_mir_during_scrub: MIR left %h while scrubbing", tag, FETCH);
        end
        checks++;
        if (wrReady !== 1'b1) begin
            errors++;
            $display("FAIL %s_wr_ready_run: got %b expected 1", tag, wrReady);
        end
        for (int i = 0; i < 2048; i++) model[i] = FETCH;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stall = 1'b0; cs = 11'd5;
        // Write requests and addresses during the scrub must be ignored.
        wrValid = 1'b1; wrAddr = 11'd7; wrData = 41'h1FFFFFFFFFF;
        repeat (3) tick();
        checks++;
        if (mir !== FETCH || initDone !== 1'b0 || wrReady !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: mir=%h done=%b ready=%b expected %h 0 0", mir, initDone, wrReady, FETCH);
        end
        scrub_and_time("t1");
        for (int i = 0; i < 2048; i++) begin
            cs = 11'(i);
            expQ.push_back(model[i]);
            tick();
            expWord = expQ.pop_front();
            checks++;
            if (mir !== expWord) begin
                errors++;
                $display("FAIL scrub_readback[%0d]: got %h expected %h", i, mir, expWord);
            end
        end
    endtask

    task automatic test_write_read();
        cs = 11'd0; wrValid = 1'b1; wrAddr = 11'd1601; wrData = 41'h0408100F7FF;
        expQ.push_back(model[0]);
        tick();
        model[1601] = 41'h0408100F7FF;
        expWord = expQ.pop_front();
        checks++;
        if (mir !== expWord) begin
            errors++;
            $display("FAIL write_cycle_read0: got %h expected %h", mir, expWord);
        end
        wrValid = 1'b0; cs = 11'd1601;
        expQ.push_back(model[1601]);
        tick();
        expWord = expQ.pop_front();
        checks++;
        if (mir !== expWord) begin
            errors++;
            $display("FAIL read_1601: got %h expected %h", mir, expWord);
        end
        // Field values decoded by hand from 41'h0408100F7FF using the MIR bit layout.
        checks++;
        if ({selA, selB, selC, rd, wrMain} !== 5'b00000) begin
            errors++;
            $display("FAIL fields_1bit: got %b expected 00000", {selA, selB, selC, rd, wrMain});
        end
        checks++;
        if (dirA !== 6'd16 || dirB !== 6'd16 || dirC !== 6'd16) begin
            errors++;
            $display("FAIL fields_dir: got %0d %0d %0d expected 16 16 16", dirA, dirB, dirC);
        end
        checks++;
        if (alu !== 4'h3 || cond !== 3'b110 || jump !== 11'h7FF) begin
            errors++;
            $display("FAIL fields_alu_cond_jump: got %h %b %h expected 3 110 7ff", alu, cond, jump);
        end
    endtask

    task automatic test_collision();
        wrValid = 1'b1; wrAddr = 11'd1584; wrData = 41'h0ABCDEF1234; cs = 11'd1584;
        model[1584] = 41'h0ABCDEF1234;
        expQ.push_back(model[1584]);
        tick();
        expWord = expQ.pop_front();
        checks++;
        if (mir !== expWord) begin
            errors++;
            $display("FAIL collision_write_first: got %h expected %h", mir, expWord);
        end
        wrValid = 1'b0;
        expQ.push_back(model[1584]);
        tick();
        expWord = expQ.pop_front();
        checks++;
        if (mir !== expWord) begin
            errors++;
            $display("FAIL collision_stored: got %h expected %h", mir, expWord);
        end
    endtask

    task automatic test_stall();
        logic [40:0] held;
        cs = 11'd0; wrValid = 1'b1;
        wrAddr = 11'd100; wrData = 41'h11111111111; tick(); model[100] = 41'h11111111111;
        wrAddr = 11'd200; wrData = 41'h02222222222; tick(); model[200] = 41'h02222222222;
        wrValid = 1'b0; cs = 11'd100;
        tick();
        held = model[100];
        checks++;
        if (mir !== held) begin
            errors++;
            $display("FAIL stall_preload: got %h expected %h", mir, held);
        end
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cs = 11'(200 + 100 * k);
            // A write landing while stalled must still reach the RAM.
            wrValid = (k == 1);
            wrAddr = 11'd300; wrData = 41'h13333333333;
            expQ.push_back(held);
            tick();
            if (k == 1) model[300] = 41'h13333333333;
            expWord = expQ.pop_front();
            checks++;
            if (mir !== expWord) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got %h expected %h", k, mir, expWord);
            end
        end
        stall = 1'b0; wrValid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cs = 11'(200 + 100 * k);
            expQ.push_back(model[200 + 100 * k]);
            tick();
            expWord = expQ.pop_front();
            checks++;
            if (mir !== expWord) begin
                errors++;
                $display("FAIL stall_release[%0d]: got %h expected %h", k, mir, expWord);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [10:0] addrs [5] = '{11'd5, 11'd1023, 11'd1600, 11'd576, 11'd1024};
        logic        wrs   [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [40:0] exps  [5] = '{41'h05555555555, 41'h07777777777, FETCH, FETCH, FETCH};
        for (int k = 0; k < 5; k++) begin
            cs2 = addrs[k]; wrAddr2 = addrs[k]; wrValid2 = wrs[k];
            wrData2 = (k == 2) ? 41'h06666666666 : exps[k];
            exp2Q.push_back(exps[k]);
            tick();
            expWord = exp2Q.pop_front();
            checks++;
            if (mir2 !== expWord) begin
                errors++;
                $display("FAIL small_range[%0d] addr %0d: got %h expected %h", k, addrs[k], mir2, expWord);
            end
        end
        wrValid2 = 1'b0;
    endtask

    task automatic test_reset_midway();
        cs = 11'd0; wrValid = 1'b1; wrAddr = 11'd1600; wrData = 41'h0DEADBEEF01;
        tick();
        model[1600] = 41'h0DEADBEEF01;
        wrValid = 1'b0; cs = 11'd1600;
        expQ.push_back(model[1600]);
        tick();
        expWord = expQ.pop_front();
        checks++;
        if (mir !== expWord) begin
            errors++;
            $display("FAIL preload_1600: got %h expected %h", mir, expWord);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (mir !== FETCH || initDone !== 1'b0 || wrReady !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_run: mir=%h done=%b ready=%b expected %h 0 0", mir, initDone, wrReady, FETCH);
        end
        tick();
        rst = 1'b0;
        repeat (500) tick();
        checks++;
        if (initDone !== 1'b0) begin
            errors++;
            $display("FAIL mid_scrub_done: got %b expected 0", initDone);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (mir !== FETCH || initDone !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_scrub: mir=%h done=%b expected %h 0", mir, initDone, FETCH);
        end
        tick();
        scrub_and_time("t6");
        cs = 11'd1600;
        expQ.push_back(model[1600]);
        tick();
        expWord = expQ.pop_front();
        checks++;
        if (mir !== expWord) begin
            errors++;
            $display("FAIL rescrub_1600: got %h expected %h", mir, expWord);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        cs = '0; stall = 1'b0; wrValid = 1'b0; wrAddr = '0; wrData = '0;
        cs2 = '0; stall2 = 1'b0; wrValid2 = 1'b0; wrAddr2 = '0; wrData2 = '0;
        tick();
        test_reset();
        test_write_read();
        test_collision();
        test_stall();
        test_out_of_range();
        test_reset_midway();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
